alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_if.sv | 46 ++++
 rtl/alu_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_if
//  Description : Handshake bundle for the sequential ALU. The issue side
//                carries an operation (opcode, operands, carry-in and
//                destination tag) under in_valid/in_ready. The result side
//                carries result, flags, destination tag and write request
//                under out_valid/out_ready.
//  Modports    : master - issuer/consumer (drives requests, out_ready)
//                slave  - ALU (drives in_ready and all result signals)
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
  parameter int WIDTH       = 32,
  parameter int OPCODE      = 4,
  parameter int REGS_CODING = 3,
  parameter int FLAGS       = 4
);
  // Issue side
  logic                   in_valid;
  logic                   in_ready;
  logic [OPCODE-1:0]      opcode;
  logic [WIDTH-1:0]       op1;
  logic [WIDTH-1:0]       op2;
  logic                   cin;
  logic [REGS_CODING-1:0] dest_in;

  // Result side
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       result;
  logic [FLAGS-1:0]       flags;
  logic [REGS_CODING-1:0] dest_out;
  logic                   wr_en;

  modport master (
    output in_valid, opcode, op1, op2, cin, dest_in, out_ready,
    input  in_ready, out_valid, result, flags, dest_out, wr_en
  );

  modport slave (
    input  in_valid, opcode, op1, op2, cin, dest_in, out_ready,
    output in_ready, out_valid, result, flags, dest_out, wr_en
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Sequential ALU with a one-deep result register. Arithmetic,
//                logic, shift, move and compare complete in one cycle.
//                Multiply (shift-add) and unsigned divide/remainder
//                (restoring) iterate one bit per cycle for WIDTH cycles.
//  Ports       : clk   - clock, rising edge
//                rst_n - synchronous active-low reset
//                bus   - alu_seq_if.slave: issue handshake (in_valid/in_ready,
//                        opcode, op1, op2, cin, dest_in) and result handshake
//                        (out_valid/out_ready, result, flags, dest_out, wr_en)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH       = 32,
  parameter int OPCODE      = 4,
  parameter int REGS_CODING = 3,
  parameter int FLAGS       = 4,
  parameter int CARRY       = 0,
  parameter int SIGN        = 1,
  parameter int OVERFLOW    = 2,
  parameter int ZERO        = 3
) (
  input logic         clk,
  input logic         rst_n,
  alu_seq_if.slave    bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH);
  localparam logic [CW-1:0] c_last_iter = CW'(WIDTH - 1);

  localparam logic [OPCODE-1:0] c_op_add  = OPCODE'(0);
  localparam logic [OPCODE-1:0] c_op_adc  = OPCODE'(1);
  localparam logic [OPCODE-1:0] c_op_sub  = OPCODE'(2);
  localparam logic [OPCODE-1:0] c_op_sbc  = OPCODE'(3);
  localparam logic [OPCODE-1:0] c_op_and  = OPCODE'(4);
  localparam logic [OPCODE-1:0] c_op_or   = OPCODE'(5);
  localparam logic [OPCODE-1:0] c_op_xor  = OPCODE'(6);
  localparam logic [OPCODE-1:0] c_op_not  = OPCODE'(7);
  localparam logic [OPCODE-1:0] c_op_shl  = OPCODE'(8);
  localparam logic [OPCODE-1:0] c_op_shr  = OPCODE'(9);
  localparam logic [OPCODE-1:0] c_op_asr  = OPCODE'(10);
  localparam logic [OPCODE-1:0] c_op_mov  = OPCODE'(11);
  localparam logic [OPCODE-1:0] c_op_cmp  = OPCODE'(12);
  localparam logic [OPCODE-1:0] c_op_mul  = OPCODE'(13);
  localparam logic [OPCODE-1:0] c_op_divu = OPCODE'(14);
  localparam logic [OPCODE-1:0] c_op_remu = OPCODE'(15);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_out_valid;
  logic [WIDTH-1:0]       r_result;
  logic [FLAGS-1:0]       r_flags;
  logic [REGS_CODING-1:0] r_dest;
  logic                   r_wr_en;

  // Iterative datapath state, loaded at accept
  logic [REGS_CODING-1:0] r_dest_hold;
  logic                   r_rem_sel;
  logic [WIDTH-1:0]       r_mcand;
  logic [2*WIDTH-1:0]     r_prod;   // {partial sum, remaining multiplier bits}
  logic [WIDTH-1:0]       r_dvs;
  logic [WIDTH-1:0]       r_quo;    // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0]       r_rem;

  // Handshake
  logic w_in_ready;
  logic w_accept;

  // in_ready is gated by rst_n so it is low throughout reset
  assign w_in_ready = rst_n && ((r_state == S_IDLE) ||
                                ((r_state == S_DONE) && bus.out_ready));
  assign w_accept   = bus.in_valid && w_in_ready;

  // ---------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] w_b;
  logic             w_ci;
  logic [WIDTH:0]   w_sum;
  logic             w_add_v;
  logic [SHW-1:0]   w_amt;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH:0]   w_shr;
  logic [WIDTH:0]   w_asr;
  logic             w_divz;

  // Subtraction reuses the adder as op1 + ~op2 + carry
  always_comb begin
    w_b  = bus.op2;
    w_ci = 1'b0;
    case (bus.opcode)
      c_op_adc:           w_ci = bus.cin;
      c_op_sub, c_op_cmp: begin w_b = ~bus.op2; w_ci = 1'b1;    end
      c_op_sbc:           begin w_b = ~bus.op2; w_ci = bus.cin; end
      default:            ;
    endcase
  end

  assign w_sum   = {1'b0, bus.op1} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_ci};
  // Overflow: both adder inputs share a sign that the sum does not
  assign w_add_v = (bus.op1[WIDTH-1] == w_b[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != bus.op1[WIDTH-1]);

  // Shifts run one bit wider so the last bit shifted out lands in the
  // extra position; with a zero amount that position holds the 0 pad.
  assign w_amt = bus.op2[SHW-1:0];
  assign w_shl = {1'b0, bus.op1} << w_amt;
  assign w_shr = {bus.op1, 1'b0} >> w_amt;
  assign w_asr = $signed({bus.op1, 1'b0}) >>> w_amt;

  assign w_divz = (bus.op2 == '0);

  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_wr;
  logic             w_multi;

  always_comb begin
    w_res   = '0;
    w_c     = 1'b0;
    w_v     = 1'b0;
    w_wr    = 1'b1;
    w_multi = 1'b0;
    case (bus.opcode)
      c_op_add, c_op_adc, c_op_sub, c_op_sbc: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = w_add_v;
      end
      c_op_cmp: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = w_add_v;
        w_wr  = 1'b0;
      end
      c_op_and: w_res = bus.op1 & bus.op2;
      c_op_or:  w_res = bus.op1 | bus.op2;
      c_op_xor: w_res = bus.op1 ^ bus.op2;
      c_op_not: w_res = ~bus.op1;
      c_op_mov: w_res = bus.op2;
      c_op_shl: begin w_res = w_shl[WIDTH-1:0]; w_c = w_shl[WIDTH]; end
      c_op_shr: begin w_res = w_shr[WIDTH:1];   w_c = w_shr[0];     end
      c_op_asr: begin w_res = w_asr[WIDTH:1];   w_c = w_asr[0];     end
      c_op_mul: w_multi = 1'b1;
      c_op_divu: begin
        if (w_divz) begin w_res = '1; w_v = 1'b1; end
        else        w_multi = 1'b1;
      end
      c_op_remu: begin
        if (w_divz) begin w_res = bus.op1; w_v = 1'b1; end
        else        w_multi = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Iterative datapath
  // ---------------------------------------------------------------------
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_prod_nxt;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH-1:0]   w_quo_nxt;
  logic [WIDTH-1:0]   w_rem_nxt;

  // Add multiplicand into the upper half when the current multiplier bit
  // is set, then shift the whole product right one place.
  assign w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} +
                      (r_prod[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
  assign w_prod_nxt = {w_mul_sum, r_prod[WIDTH-1:1]};

  // Trial subtract of the shifted partial remainder; the top bit set
  // means it went negative and the old value is restored.
  assign w_trial   = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dvs};
  assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
  assign w_rem_nxt = w_trial[WIDTH] ? {r_rem[WIDTH-2:0], r_quo[WIDTH-1]}
                                    : w_trial[WIDTH-1:0];

  function automatic logic [FLAGS-1:0] mk_flags(input logic [WIDTH-1:0] res,
                                                input logic c,
                                                input logic v);
    logic [FLAGS-1:0] f;
    f           = '0;
    f[CARRY]    = c;
    f[SIGN]     = res[WIDTH-1];
    f[OVERFLOW] = v;
    f[ZERO]     = (res == '0);
    return f;
  endfunction

  // ---------------------------------------------------------------------
  // Control FSM and output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
      r_dest      <= '0;
      r_wr_en     <= 1'b0;
      r_dest_hold <= '0;
      r_rem_sel   <= 1'b0;
      r_mcand     <= '0;
      r_prod      <= '0;
      r_dvs       <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
    end else if (w_accept) begin
      // Accept happens only in IDLE or in DONE together with a retire
      if (w_multi) begin
        r_out_valid <= 1'b0;
        r_state     <= (bus.opcode == c_op_mul) ? S_MUL : S_DIV;
        r_cnt       <= '0;
        r_dest_hold <= bus.dest_in;
        r_rem_sel   <= (bus.opcode == c_op_remu);
        r_mcand     <= bus.op1;
        r_prod      <= {{WIDTH{1'b0}}, bus.op2};
        r_dvs       <= bus.op2;
        r_quo       <= bus.op1;
        r_rem       <= '0;
      end else begin
        r_out_valid <= 1'b1;
        r_state     <= S_DONE;
        r_result    <= w_res;
        r_flags     <= mk_flags(w_res, w_c, w_v);
        r_dest      <= bus.dest_in;
        r_wr_en     <= w_wr;
      end
    end else begin
      case (r_state)
        S_MUL: begin
          r_prod <= w_prod_nxt;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == c_last_iter) begin
            r_state     <= S_DONE;
            r_cnt       <= '0;
            r_out_valid <= 1'b1;
            r_result    <= w_prod_nxt[WIDTH-1:0];
            r_flags     <= mk_flags(w_prod_nxt[WIDTH-1:0],
                                    |w_prod_nxt[2*WIDTH-1:WIDTH], 1'b0);
            r_dest      <= r_dest_hold;
            r_wr_en     <= 1'b1;
          end
        end
        S_DIV: begin
          r_quo <= w_quo_nxt;
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_last_iter) begin
            r_state     <= S_DONE;
            r_cnt       <= '0;
            r_out_valid <= 1'b1;
            r_result    <= r_rem_sel ? w_rem_nxt : w_quo_nxt;
            r_flags     <= mk_flags(r_rem_sel ? w_rem_nxt : w_quo_nxt,
                                    1'b0, 1'b0);
            r_dest      <= r_dest_hold;
            r_wr_en     <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.flags     = r_flags;
  assign bus.dest_out  = r_dest;
  assign bus.wr_en     = r_wr_en;

endmodule
`default_nettype wire
